overlay_reveal_mixer: RTL
=========================

Name: overlay_reveal_mixer

Overview:
Output stage directly downstream of the emblem overlay generator. Composites the overlay's draw/rgb over the background pixel, gated by a frame-synchronous top-down wipe reveal/hide state machine. Registers final RGB and the sync signals toward the VGA pins. All outputs emerge with one aligned cycle of latency.

Parameters:
OV_Y0, 144, first screen line of overlay region
OV_HEIGHT, 176, overlay region height in lines (1..255)
WIPE_STEP, 4, lines revealed/hidden per frame (1..OV_HEIGHT)
HOLD_FRAMES, 120, minimum frames fully shown before wipe-out is allowed (0..255)
VSYNC_ACTIVE_LOW, 1, 1 = vsync asserted low, 0 = asserted high

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hsync_in  in  1  hsync from timing generator
vsync_in  in  1  vsync from timing generator
active_in  in  1  visible-region flag
y_in  in  10  current line
bg_rgb  in  6  background pixel {R1R0,G1G0,B1B0}
ov_draw  in  1  overlay pixel valid
ov_rgb  in  6  overlay pixel colour
show  in  1  level request to display overlay, synchronous to clk
rgb_out  out  6  registered composited pixel
hsync_out  out  1  hsync delayed 1 cycle
vsync_out  out  1  vsync delayed 1 cycle
state_out  out  2  current FSM state
busy  out  1  high in WIPE_IN or WIPE_OUT

Behaviour:
- Clock clk, reset rst_n asynchronous active-low; all flops clear immediately on rst_n=0.
- Reset values: rgb_out=0; hsync_out and vsync_out = inactive level (1 when VSYNC_ACTIVE_LOW=1, else 0; hsync follows the same polarity); state=HIDDEN (0); reveal=0; hold_cnt=0; vsync_prev=inactive; busy=0.
- Frame tick: one-cycle pulse in the cycle when registered vsync_prev is inactive and vsync_in is asserted (leading edge). No tick in the first cycle after reset unless vsync_in is already asserted.
- FSM, updated only on tick; show sampled in the tick cycle:
  HIDDEN(0): reveal=0; show=1 -> WIPE_IN.
  WIPE_IN(1): reveal=min(reveal+WIPE_STEP, OV_HEIGHT), computed in 9 bits; reaching OV_HEIGHT -> SHOWN, hold_cnt=0; show=0 -> WIPE_OUT with reveal unchanged on that tick.
  SHOWN(2): hold_cnt saturating increment up to HOLD_FRAMES; show=0 and hold_cnt>=HOLD_FRAMES (value before increment) -> WIPE_OUT; otherwise stay.
  WIPE_OUT(3): reveal=max(reveal-WIPE_STEP, 0), with no underflow; reaching 0 -> HIDDEN; show=1 -> WIPE_IN with reveal unchanged.
- reveal is 8 bits. Overlay region rows are rel=y_in-OV_Y0, valid only when y_in>=OV_Y0.
- Pixel path: visible = ov_draw & (y_in>=OV_Y0) & (rel<reveal), compared as 10-bit zero-extended.
- Output register: rgb_out <= active_in ? (visible ? ov_rgb : bg_rgb) : 6'b0.
- Output register: hsync_out <= hsync_in; vsync_out <= vsync_in.
- Latency is exactly 1 cycle for rgb, hsync and vsync, so the three stay aligned.
- reveal changes only at the vsync leading edge, so no partially updated visible frame (no tearing).
- Reset mid-wipe: returns to HIDDEN, reveal=0; overlay disappears on the next pixel.
- busy and state_out are combinational decodes of the state register.

Decomposition:
- Shared package holds: state enum (HIDDEN/WIPE_IN/SHOWN/WIPE_OUT, 2 bits), colour constants (BLACK 000000, etc.), and sync-polarity helper constants.
- One sub-module, frame_tick_det: vsync edge detector with polarity parameter and tick output.
- FSM and pixel register stay in the top module.

Test Plan:
- Reset with rst_n=0 mid-frame: rgb_out=0, vsync_out=hsync_out=1, state_out=0, busy=0, asynchronously, before any clock edge.
- Pass-through: show=0, active_in=1, bg_rgb=6'h2A, ov_draw=1, y_in=200, ov_rgb=6'h36: rgb_out=6'h2A one cycle later. Same inputs with active_in=0: rgb_out=0. hsync_out/vsync_out mirror the inputs delayed 1 cycle.
- Wipe-in: show=1, 3 vsync edges, WIPE_STEP=4: reveal=12. ov_draw=1, ov_rgb=6'h36: y_in=155 gives rgb_out=6'h36; y_in=156 gives bg_rgb. state_out=1, busy=1.
- Full reveal and hold, HOLD_FRAMES=2: 44 ticks give reveal=176 and state=2. Drop show: stays SHOWN for 2 ticks, enters WIPE_OUT on the 3rd tick; after 44 more ticks state=0, reveal=0.
- Reversal: show=1 for 10 ticks (reveal=40), then show=0 on the tick: state=3, reveal stays 40; next tick reveal=36.
- Saturation: WIPE_STEP=5, OV_HEIGHT=176: the 36th tick clamps reveal to 176, not 180. In WIPE_OUT from reveal=3: next tick gives reveal=0 and HIDDEN, with no underflow.

Source files
------------

// File: rtl/overlay_reveal_mixer_pkg.sv
// Shared types and constants for the overlay reveal mixer.
// Holds the wipe FSM states, colour constants and sync-polarity helpers.
package overlay_reveal_mixer_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        WIPE_IN  = 2'd1,
        SHOWN    = 2'd2,
        WIPE_OUT = 2'd3
    } wipe_state_e;

    localparam logic [5:0] BLACK = 6'h00;
    localparam logic [5:0] WHITE = 6'h3F;
    localparam logic [5:0] RED   = 6'h30;
    localparam logic [5:0] GREEN = 6'h0C;
    localparam logic [5:0] BLUE  = 6'h03;

    // Idle (deasserted) sync level for a given polarity.
    function automatic logic sync_idle(input logic active_low);
        return active_low;
    endfunction

    // Asserted sync level for a given polarity.
    function automatic logic sync_on(input logic active_low);
        return ~active_low;
    endfunction

endpackage

// File: rtl/overlay_reveal_mixer_frame_tick.sv
// Vsync leading-edge detector producing a one-cycle frame tick.
// Ports: clk, rst_n, vsync_in (raw vsync), tick (pulse on assertion edge).
module frame_tick_det
    import overlay_reveal_mixer_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic tick
);

    localparam logic IDLE = sync_idle(ACTIVE_LOW);

    logic vsync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev <= IDLE;
        end else begin
            vsync_prev <= vsync_in;
        end
    end

    // Prior sample idle, current sample asserted.
    assign tick = (vsync_prev == IDLE) && (vsync_in != IDLE);

endmodule

// File: rtl/overlay_reveal_mixer.sv
// Composites overlay pixels over background behind a top-down wipe.
// Ports: sync/active/y/bg/overlay in, show request; registered rgb/syncs out, state_out, busy.
module overlay_reveal_mixer
    import overlay_reveal_mixer_pkg::*;
#(
    parameter int OV_Y0            = 144,
    parameter int OV_HEIGHT        = 176,
    parameter int WIPE_STEP        = 4,
    parameter int HOLD_FRAMES      = 120,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [9:0] y_in,
    input  logic [5:0] bg_rgb,
    input  logic       ov_draw,
    input  logic [5:0] ov_rgb,
    input  logic       show,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [1:0] state_out,
    output logic       busy
);

    localparam logic       IDLE    = sync_idle(VSYNC_ACTIVE_LOW);
    localparam logic [9:0] Y0      = 10'(OV_Y0);
    localparam logic [8:0] HEIGHT9 = 9'(OV_HEIGHT);
    localparam logic [7:0] HEIGHT8 = 8'(OV_HEIGHT);
    localparam logic [8:0] STEP9   = 9'(WIPE_STEP);
    localparam logic [7:0] STEP8   = 8'(WIPE_STEP);
    localparam logic [7:0] HOLD8   = 8'(HOLD_FRAMES);

    wipe_state_e state, state_n;
    logic [7:0]  reveal, reveal_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [8:0]  sum9;
    logic        tick;

    frame_tick_det #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HIDDEN;
            reveal   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            reveal   <= reveal_n;
            hold_cnt <= hold_n;
        end
    end

    // Wide sum so the clamp sees a carry past 255.
    assign sum9 = {1'b0, reveal} + STEP9;

    always_comb begin
        state_n  = state;
        reveal_n = reveal;
        hold_n   = hold_cnt;
        if (tick) begin
            unique case (state)
                HIDDEN: begin
                    reveal_n = '0;
                    if (show) state_n = WIPE_IN;
                end
                WIPE_IN: begin
                    if (!show) begin
                        state_n = WIPE_OUT;
                    end else if (sum9 >= HEIGHT9) begin
                        reveal_n = HEIGHT8;
                        hold_n   = '0;
                        state_n  = SHOWN;
                    end else begin
                        reveal_n = sum9[7:0];
                    end
                end
                SHOWN: begin
                    if (hold_cnt < HOLD8) hold_n = hold_cnt + 8'd1;
                    if (!show && hold_cnt >= HOLD8) state_n = WIPE_OUT;
                end
                WIPE_OUT: begin
                    if (show) begin
                        state_n = WIPE_IN;
                    end else if (reveal <= STEP8) begin
                        reveal_n = '0;
                        state_n  = HIDDEN;
                    end else begin
                        reveal_n = reveal - STEP8;
                    end
                end
                default: begin
                    state_n  = HIDDEN;
                    reveal_n = '0;
                end
            endcase
        end
    end

    logic [9:0] rel;
    logic       in_rows;
    logic       visible;
    logic [5:0] pix;

    assign rel     = y_in - Y0;
    assign in_rows = (y_in >= Y0);
    assign visible = ov_draw & in_rows & (rel < {2'b00, reveal});
    assign pix     = active_in ? (visible ? ov_rgb : bg_rgb) : BLACK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= BLACK;
            hsync_out <= IDLE;
            vsync_out <= IDLE;
        end else begin
            rgb_out   <= pix;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

    assign state_out = state;
    assign busy      = (state == WIPE_IN) || (state == WIPE_OUT);

endmodule
